booth_mult_n: RTL



---
 rtl/booth_mult_n.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/booth_mult_n.sv
// Radix-2 Booth multiplier for two's-complement operands, with a start/done handshake.
// Defining BOOTH_UNSIGNED_EN adds the tc port for unsigned operands (tc=0).
module booth_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int IW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = IW;
`else
  localparam int QW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [IW-1:0]        a_r;
  logic [IW-1:0]        m_r;
  logic [QW-1:0]        q_r;
  logic                 qm1_r;
  logic [CW-1:0]        cnt_r;
  logic [IW-1:0]        z_s;
  logic [IW-1:0]        load_m_s;
  logic [QW-1:0]        load_q_s;
  logic [CW-1:0]        load_cnt_s;
  logic [2*WIDTH-1:0]   result_s;
`ifdef BOOTH_UNSIGNED_EN
  logic                 tc_r;
`endif

  // Operand extension and iteration count selected at start
  always_comb begin
    load_m_s   = {multiplicand[WIDTH-1], multiplicand};
    load_cnt_s = CW'(WIDTH);
`ifdef BOOTH_UNSIGNED_EN
    load_q_s   = {multiplier[WIDTH-1], multiplier};
    if (!tc) begin
      // Unsigned: zero-extend and run one extra iteration for the sign-free top bit
      load_m_s   = {1'b0, multiplicand};
      load_q_s   = {1'b0, multiplier};
      load_cnt_s = CW'(WIDTH + 1);
    end else begin
      load_m_s   = {multiplicand[WIDTH-1], multiplicand};
      load_q_s   = {multiplier[WIDTH-1], multiplier};
      load_cnt_s = CW'(WIDTH);
    end
`else
    load_q_s   = multiplier;
`endif
  end

  // Booth recoding of {Q[0], q_m1} and final product selection
  always_comb begin
    case ({q_r[0], qm1_r})
      2'b01:   z_s = a_r + m_r;
      2'b10:   z_s = a_r - m_r;
      default: z_s = a_r;
    endcase
`ifdef BOOTH_UNSIGNED_EN
    if (tc_r) begin
      result_s = {a_r[WIDTH-1:0], q_r[WIDTH:1]};
    end else begin
      result_s = {a_r[WIDTH-2:0], q_r};
    end
`else
    result_s = {a_r[WIDTH-1:0], q_r};
`endif
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {IW{1'b0}};
      m_r     <= {IW{1'b0}};
      q_r     <= {QW{1'b0}};
      qm1_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
`ifdef BOOTH_UNSIGNED_EN
      tc_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_r == RUN) || (state_r == DONE) || ((state_r == IDLE) && start);
      done    <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= {IW{1'b0}};
            m_r   <= load_m_s;
            q_r   <= load_q_s;
            qm1_r <= 1'b0;
            cnt_r <= load_cnt_s;
`ifdef BOOTH_UNSIGNED_EN
            tc_r  <= tc;
`endif
          end
        end
        RUN: begin
          // Arithmetic right shift of {Z, Q, q_m1}
          a_r   <= {z_s[IW-1], z_s[IW-1:1]};
          q_r   <= {z_s[0], q_r[QW-1:1]};
          qm1_r <= q_r[0];
          cnt_r <= cnt_r - CW'(1);
        end
        DONE:    product <= result_s;
        default: ;
      endcase
    end
  end

endmodule
